// File: rtl/dot_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// dot_matrix_scan_ctrl : digit FIFO + row scanner for a 5x3 dot-matrix decoder
// Revision: 1.0
// ============================================================================
module dot_matrix_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DWELL_FRAMES = 60,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [3:0] in_digit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] digit_sel,
    input  logic [2:0] pat_a,
    input  logic [2:0] pat_b,
    input  logic [2:0] pat_c,
    input  logic [2:0] pat_d,
    input  logic [2:0] pat_e,
    output logic [4:0] row_en,
    output logic [2:0] col_out,
    output logic       busy,
    output logic       frame_tick
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_div_w = $clog2(SCAN_DIV);
    localparam int c_frm_w = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t               r_state;
    logic [3:0]           r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_div_w-1:0]   r_div_cnt;
    logic [2:0]           r_row_idx;
    logic [c_frm_w-1:0]   r_frame_cnt;
    logic [3:0]           r_digit_sel;
    logic [4:0]           r_row_en;
    logic                 r_busy;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_div_term;
    logic w_frame_end;
    logic w_dwell_done;
    logic [2:0] w_col;

    assign w_full       = (r_count == c_cnt_w'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = in_valid && !w_full && !clear;
    assign w_div_term   = (r_div_cnt == c_div_w'(SCAN_DIV - 1));
    assign w_frame_end  = (r_state == ST_SHOW) && w_div_term && (r_row_idx == 3'd4);
    assign w_dwell_done = (r_frame_cnt == c_frm_w'(DWELL_FRAMES - 1));
    // Pop either to start showing from IDLE, or when a dwell has fully elapsed.
    assign w_pop        = !clear && !w_empty &&
                          ((r_state == ST_IDLE) || (w_frame_end && w_dwell_done));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_digit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_row_idx   <= 3'd0;
            r_frame_cnt <= '0;
            r_digit_sel <= 4'd0;
            r_row_en    <= 5'd0;
            r_busy      <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_row_idx   <= 3'd0;
            r_frame_cnt <= '0;
            r_row_en    <= 5'd0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_digit_sel <= r_mem[r_rd_ptr];
                        r_div_cnt   <= '0;
                        r_row_idx   <= 3'd0;
                        r_frame_cnt <= '0;
                        r_row_en    <= 5'b00001;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (w_div_term) begin
                        r_div_cnt <= '0;
                        if (r_row_idx == 3'd4) begin
                            r_row_idx <= 3'd0;
                            r_row_en  <= 5'b00001;
                            // With an empty FIFO the frame count stays saturated so
                            // the next arrival loads on the very next frame end.
                            if (w_dwell_done) begin
                                if (!w_empty) begin
                                    r_digit_sel <= r_mem[r_rd_ptr];
                                    r_frame_cnt <= '0;
                                end
                            end else begin
                                r_frame_cnt <= r_frame_cnt + c_frm_w'(1);
                            end
                        end else begin
                            r_row_idx <= r_row_idx + 3'd1;
                            r_row_en  <= r_row_en << 1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + c_div_w'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_col = 3'd0;
        case (r_row_idx)
            3'd0:    w_col = pat_a;
            3'd1:    w_col = pat_b;
            3'd2:    w_col = pat_c;
            3'd3:    w_col = pat_d;
            3'd4:    w_col = pat_e;
            default: w_col = 3'd0;
        endcase
    end

    assign in_ready   = !w_full;
    assign digit_sel  = r_digit_sel;
    assign row_en     = r_row_en;
    assign busy       = r_busy;
    assign col_out    = r_busy ? w_col : 3'd0;
    assign frame_tick = w_frame_end;

endmodule
`default_nettype wire
